tug_of_war_controller: RTL and testbench
========================================

Name: tug_of_war_controller

Overview:
- Two-player tug-of-war game controller.
- Conditions two raw player keys (2-FF synchronizer plus one-pulse-per-press edge detector, one chain per key).
- Arbitrates simultaneous presses and moves a one-hot light along a playfield of FIELD_W LEDs.
- Sequences points, post-point lockout, per-player scores and match end; drives the board LEDs and a winner indicator.

Parameters:
- FIELD_W, 9: playfield LED count; odd, >= 3; centre index C = FIELD_W/2 (4 by default).
- SCORE_MAX, 7: points needed to win the match; 1..7.
- LOCKOUT, 8: cycles after a point during which presses are ignored; 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- keyL  in  1  raw left-player key, asynchronous, active-high.
- keyR  in  1  raw right-player key, asynchronous, active-high.
- leds  out  FIELD_W  playfield; leds[FIELD_W-1] is leftmost, leds[0] rightmost.
- scoreL  out  3  left player score, unsigned.
- scoreR  out  3  right player score, unsigned.
- point  out  1  one-cycle pulse when a point is awarded.
- winner  out  2  2'b00 none, 2'b10 left won, 2'b01 right won.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values (applied at the clk edge with reset=1):
  - state PLAY, pos=C, leds one-hot at C (9'b000010000 by default);
  - scoreL=scoreR=0, point=0, winner=00, lockout counter 0;
  - all synchronizer and edge-detector flops 0.
- Reset mid-match aborts everything and returns to the reset values. A key held through reset yields exactly one press after reset deasserts.
- Input conditioning, per key:
  - s1 <= key; s2 <= s1; s3 <= s2.
  - Press pulse pX = s2 & ~s3 (one cycle per 0->1 transition of s2).
  - A held key produces one pulse only.
- Latency: raw key rises before edge E0 -> pos/leds change at edge E0+2.
- Arbitration, PLAY state only:
  - pL & pR in the same cycle -> no move (cancel).
  - pL only -> pos+1; pR only -> pos-1.
- Point rule, PLAY state:
  - pL alone with pos==FIELD_W-1 -> left point: scoreL+1, point=1 for one cycle, pos<=C.
  - pR alone with pos==0 -> right point: scoreR+1, point=1 for one cycle, pos<=C.
  - pos never wraps.
- State machine:
  - PLAY: leds one-hot(pos). On a point whose new score < SCORE_MAX -> LOCKOUT with counter loaded with LOCKOUT-1. If the new score == SCORE_MAX -> OVER.
  - LOCKOUT: leds all 0; press pulses discarded; edge detectors keep running. Counter decrements each cycle; when it reads 0 -> PLAY, with leds one-hot at C on the next cycle. Lasts exactly LOCKOUT cycles.
  - OVER: leds all 0; winner = 10 (left) or 01 (right), registered on the same edge as the final score; scores frozen; all presses ignored until reset.
- A key held across the end of LOCKOUT does not move the light; a fresh press is required.
- Scores never exceed SCORE_MAX. point and winner are registered outputs.

Test Plan:
- Reset 3 cycles, keys 0 -> leds=9'b000010000, scores 0, winner=00, point=0.
- keyL raised before edge E0 and held 10 cycles -> leds=9'b000100000 at E0+2; no further movement while held.
- keyL and keyR raised in the same cycle -> leds stay 9'b000010000; then release both.
- Five separate keyL presses from centre -> 4th press reaches leds=9'b100000000; 5th gives point=1 for one cycle, scoreL=1, leds=0 for 8 cycles, then 9'b000010000. A keyR press during lockout has no effect.
- Left wins 7 points -> winner=10, scoreL=7, leds=0, all further presses ignored. reset=1 for one edge -> full reset values.
- Reset asserted mid-lockout with scoreR=3 -> next cycle scoreR=0, state PLAY, leds=9'b000010000.

Source files
------------

// File: rtl/tug_of_war_controller.sv
// ============================================================================
// Module   : tug_of_war_controller
// Brief    : Two-player tug-of-war game: key conditioning, light movement,
//            point/lockout sequencing, scores and match winner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tug_of_war_controller #(
    parameter int FIELD_W   = 9,
    parameter int SCORE_MAX = 7,
    parameter int LOCKOUT   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               keyL,
    input  logic               keyR,
    output logic [FIELD_W-1:0] leds,
    output logic [2:0]         scoreL,
    output logic [2:0]         scoreR,
    output logic               point,
    output logic [1:0]         winner
);

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_LOCK = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [FIELD_W-1:0] c_CENTER_LEDS = FIELD_W'(1) << (FIELD_W / 2);
    localparam logic [2:0]         c_SCORE_MAX   = 3'(SCORE_MAX);
    localparam logic [15:0]        c_LOCK_LOAD   = 16'(LOCKOUT - 1);

    logic [1:0]         r_state;
    logic [15:0]        r_cnt;
    logic [FIELD_W-1:0] r_leds;
    logic [2:0]         r_scoreL;
    logic [2:0]         r_scoreR;
    logic               r_point;
    logic [1:0]         r_winner;
    logic               r_keyl_s1, r_keyl_s2, r_keyl_s3;
    logic               r_keyr_s1, r_keyr_s2, r_keyr_s3;

    logic       w_pl, w_pr, w_move_l, w_move_r, w_pt_l, w_pt_r;
    logic [2:0] w_scl_inc, w_scr_inc;

    assign w_pl      = r_keyl_s2 & ~r_keyl_s3;
    assign w_pr      = r_keyr_s2 & ~r_keyr_s3;
    assign w_move_l  = w_pl & ~w_pr;
    assign w_move_r  = w_pr & ~w_pl;
    // In PLAY the one-hot LED vector is the light position itself.
    assign w_pt_l    = w_move_l & r_leds[FIELD_W-1];
    assign w_pt_r    = w_move_r & r_leds[0];
    assign w_scl_inc = r_scoreL + 3'd1;
    assign w_scr_inc = r_scoreR + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_PLAY;
            r_cnt     <= 16'd0;
            r_leds    <= c_CENTER_LEDS;
            r_scoreL  <= 3'd0;
            r_scoreR  <= 3'd0;
            r_point   <= 1'b0;
            r_winner  <= 2'b00;
            r_keyl_s1 <= 1'b0;
            r_keyl_s2 <= 1'b0;
            r_keyl_s3 <= 1'b0;
            r_keyr_s1 <= 1'b0;
            r_keyr_s2 <= 1'b0;
            r_keyr_s3 <= 1'b0;
        end else begin
            r_keyl_s1 <= keyL;
            r_keyl_s2 <= r_keyl_s1;
            r_keyl_s3 <= r_keyl_s2;
            r_keyr_s1 <= keyR;
            r_keyr_s2 <= r_keyr_s1;
            r_keyr_s3 <= r_keyr_s2;
            r_point   <= 1'b0;

            case (r_state)
                S_PLAY: begin
                    if (w_pt_l) begin
                        r_scoreL <= w_scl_inc;
                        r_point  <= 1'b1;
                        r_leds   <= '0;
                        if (w_scl_inc == c_SCORE_MAX) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b10;
                        end else begin
                            r_state <= S_LOCK;
                            r_cnt   <= c_LOCK_LOAD;
                        end
                    end else if (w_pt_r) begin
                        r_scoreR <= w_scr_inc;
                        r_point  <= 1'b1;
                        r_leds   <= '0;
                        if (w_scr_inc == c_SCORE_MAX) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b01;
                        end else begin
                            r_state <= S_LOCK;
                            r_cnt   <= c_LOCK_LOAD;
                        end
                    end else if (w_move_l) begin
                        r_leds <= r_leds << 1;
                    end else if (w_move_r) begin
                        r_leds <= r_leds >> 1;
                    end
                end
                S_LOCK: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= S_PLAY;
                        r_leds  <= c_CENTER_LEDS;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_PLAY;
                    r_leds  <= c_CENTER_LEDS;
                end
            endcase
        end
    end

    assign leds   = r_leds;
    assign scoreL = r_scoreL;
    assign scoreR = r_scoreR;
    assign point  = r_point;
    assign winner = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_tug_of_war_controller.sv
// ============================================================================
// Module   : tb_tug_of_war_controller
// Brief    : Directed stimulus with cycle-tagged expectations in a scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tug_of_war_controller;

    typedef struct {
        int         cyc;
        int         id;
        logic [8:0] leds;
        logic [2:0] sl;
        logic [2:0] sr;
        logic       pt;
        logic [1:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       keyL, keyR;
    logic [8:0] leds;
    logic [2:0] scoreL, scoreR;
    logic       point;
    logic [1:0] winner;

    int   ecnt    = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   npoints = 0;
    int   next_id = 0;
    exp_t q[$];

    localparam logic [8:0] CEN = 9'b000010000;

    tug_of_war_controller #(.FIELD_W(9), .SCORE_MAX(7), .LOCKOUT(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .keyL   (keyL),
        .keyR   (keyR),
        .leds   (leds),
        .scoreL (scoreL),
        .scoreR (scoreR),
        .point  (point),
        .winner (winner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected outputs as seen d edges from now.
    task automatic expect_at(input int d, input logic [8:0] l, input logic [2:0] sl,
                             input logic [2:0] sr, input logic pt, input logic [1:0] w);
        exp_t e;
        int   i;
        e.cyc = ecnt + d; e.id = next_id; e.leds = l;
        e.sl = sl; e.sr = sr; e.pt = pt; e.w = w;
        next_id++;
        i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (point) npoints++;
            while (q.size() > 0 && q[0].cyc <= ecnt) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != ecnt || leds !== e.leds || scoreL !== e.sl ||
                    scoreR !== e.sr || point !== e.pt || winner !== e.w) begin
                    errors++;
                    $display("FAIL chk%0d cyc%0d: got leds=%b sL=%0d sR=%0d pt=%b win=%b, expected leds=%b sL=%0d sR=%0d pt=%b win=%b (at cyc%0d)",
                             e.id, ecnt, leds, scoreL, scoreR, point, winner,
                             e.leds, e.sl, e.sr, e.pt, e.w, e.cyc);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; keyL = 1'b0; keyR = 1'b0;
        tick(3);
        expect_at(0, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        reset = 1'b0;
        tick(2);

        // Held left key: exactly one step at E0+2.
        keyL = 1'b1;
        expect_at(2, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        expect_at(3, 9'b000100000, 3'd0, 3'd0, 1'b0, 2'b00);
        expect_at(10, 9'b000100000, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(10); keyL = 1'b0; tick(3);

        // Right press moves back to centre.
        keyR = 1'b1;
        expect_at(3, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(2); keyR = 1'b0; tick(3);

        // Simultaneous presses cancel.
        keyL = 1'b1; keyR = 1'b1;
        expect_at(3, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        expect_at(6, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(2); keyL = 1'b0; keyR = 1'b0; tick(4);

        // Left points: first one with lockout and a right press inside it.
        for (int p = 1; p <= 7; p++) begin
            for (int i = 1; i <= 4; i++) begin
                keyL = 1'b1;
                expect_at(3, CEN << i, 3'(p - 1), 3'd0, 1'b0, 2'b00);
                tick(2); keyL = 1'b0; tick(3);
            end
            keyL = 1'b1;
            if (p < 7) begin
                expect_at(3, 9'd0, 3'(p), 3'd0, 1'b1, 2'b00);
                expect_at(4, 9'd0, 3'(p), 3'd0, 1'b0, 2'b00);
                expect_at(10, 9'd0, 3'(p), 3'd0, 1'b0, 2'b00);
                expect_at(11, CEN, 3'(p), 3'd0, 1'b0, 2'b00);
                if (p == 1) begin
                    expect_at(13, CEN, 3'd1, 3'd0, 1'b0, 2'b00);
                    tick(2); keyL = 1'b0; tick(1);
                    keyR = 1'b1; tick(10); keyR = 1'b0; tick(4);
                end else begin
                    tick(2); keyL = 1'b0; tick(12);
                end
            end else begin
                expect_at(3, 9'd0, 3'd7, 3'd0, 1'b1, 2'b10);
                expect_at(4, 9'd0, 3'd7, 3'd0, 1'b0, 2'b10);
                tick(2); keyL = 1'b0; tick(3);
            end
        end

        // Match over: every press ignored.
        keyL = 1'b1; tick(2); keyL = 1'b0; tick(3);
        keyR = 1'b1; tick(2); keyR = 1'b0; tick(3);
        keyL = 1'b1; keyR = 1'b1; tick(2); keyL = 1'b0; keyR = 1'b0;
        expect_at(4, 9'd0, 3'd7, 3'd0, 1'b0, 2'b10);
        tick(5);

        reset = 1'b1;
        expect_at(1, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(1); reset = 1'b0; tick(2);

        // Three right points, then reset during the third lockout.
        for (int p = 1; p <= 3; p++) begin
            for (int i = 1; i <= 4; i++) begin
                keyR = 1'b1;
                expect_at(3, CEN >> i, 3'd0, 3'(p - 1), 1'b0, 2'b00);
                tick(2); keyR = 1'b0; tick(3);
            end
            keyR = 1'b1;
            expect_at(3, 9'd0, 3'd0, 3'(p), 1'b1, 2'b00);
            if (p < 3) begin
                expect_at(11, CEN, 3'd0, 3'(p), 1'b0, 2'b00);
                tick(2); keyR = 1'b0; tick(12);
            end else begin
                expect_at(5, 9'd0, 3'd0, 3'd3, 1'b0, 2'b00);
                tick(2); keyR = 1'b0; tick(3);
            end
        end

        // Key held through reset yields a single press afterwards.
        reset = 1'b1; keyL = 1'b1;
        expect_at(1, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(1); reset = 1'b0;
        expect_at(2, CEN, 3'd0, 3'd0, 1'b0, 2'b00);
        expect_at(3, 9'b000100000, 3'd0, 3'd0, 1'b0, 2'b00);
        expect_at(7, 9'b000100000, 3'd0, 3'd0, 1'b0, 2'b00);
        tick(8); keyL = 1'b0; tick(3);

        checks++;
        if (npoints != 10) begin
            errors++;
            $display("FAIL point_count: got %0d pulses, expected 10", npoints);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
